mem_port_arbiter: RTL and testbench

Shares the single byte-addressed data-memory port between the instruction-fetch requester (I) and the load/store requester (D) of the five-stage pipeline. Each cycle it grants at most one requester, drives the memory's address/read_write/access_size/data_in, and captures the memory's combinational read data into a registered response. D normally wins for pipeline-order reasons. A starvation counter guarantees I forward progress.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between fetch (I) and load/store (D).
// Define MEM_ARB_ALIGN_CHECK_EN to flag misaligned D accesses on d_err instead of issuing them.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_address,
   output logic        mem_read_write,
   output logic [1:0]  mem_access_size,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic [3:0]  starve_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Handshake: a requester holds req and its payload stable until it sees gnt in the
   // same cycle; the access completes and rvalid pulses exactly one cycle after gnt.
   logic [3:0]  starve_q, starve_d;
   logic        i_rvalid_q, d_rvalid_q, d_err_q;
   logic [31:0] i_rdata_q, d_rdata_q;
   logic        i_win, d_mis;

`ifdef MEM_ARB_ALIGN_CHECK_EN
   assign d_mis = ((d_size == 2'd1) && d_addr[0])
                | ((d_size == 2'd2) && (d_addr[1:0] != 2'b00))
                | (d_size == 2'd3);
`else
   assign d_mis = 1'b0;
`endif

   // I wins contention only once D has been granted over it LIMIT times in a row.
   assign i_win = i_req && (!d_req || (starve_q == LIMIT));
   assign i_gnt = rst_n && i_win;
   assign d_gnt = rst_n && d_req && !i_win;

   always_comb begin
      starve_d = 4'd0;
      if (d_gnt && i_req) begin
         starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
      end
   end

   always_comb begin
      mem_address     = 32'd0;
      mem_read_write  = 1'b0;
      mem_access_size = 2'd2;
      mem_data_in     = 32'd0;
      if (d_gnt) begin
         mem_address     = d_addr;
         mem_read_write  = d_rw && !d_mis;
         mem_access_size = d_size;
         mem_data_in     = d_wdata;
      end else if (i_gnt) begin
         mem_address = i_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q   <= 4'd0;
         i_rvalid_q <= 1'b0;
         i_rdata_q  <= 32'd0;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= 32'd0;
         d_err_q    <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         i_rvalid_q <= i_gnt;
         d_rvalid_q <= d_gnt;
         d_err_q    <= d_gnt && d_mis;
         if (i_gnt) begin
            i_rdata_q <= mem_data_out;
         end
         // Stores and rejected accesses return zero data.
         if (d_gnt) begin
            d_rdata_q <= (d_rw || d_mis) ? 32'd0 : mem_data_out;
         end
      end
   end

   assign i_rvalid   = i_rvalid_q;
   assign i_rdata    = i_rdata_q;
   assign d_rvalid   = d_rvalid_q;
   assign d_rdata    = d_rdata_q;
   assign d_err      = d_err_q;
   assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory environment, reference model checked every
// negedge, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = 2'd2;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic [3:0]  starve_cnt;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_access_size(mem_access_size), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .starve_cnt(starve_cnt)
  );

  // ---------------- memory environment (combinational read, write at edge)
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ma;
  assign ma = mem_address[7:0];
  assign mem_data_out = {ram[ma + 8'd3], ram[ma + 8'd2], ram[ma + 8'd1], ram[ma]};

  always @(posedge clk) begin
    if (mem_read_write) begin
      ram[ma] <= mem_data_in[7:0];
      if (mem_access_size != 2'd0) ram[ma + 8'd1] <= mem_data_in[15:8];
      if (mem_access_size[1]) begin
        ram[ma + 8'd2] <= mem_data_in[23:16];
        ram[ma + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd3);
`else
    return 1'b0;
`endif
  endfunction

  int          m_run;           // consecutive D wins over a waiting I
  logic        m_irv, m_drv, m_derr;
  logic [31:0] m_irdata, m_drdata;

  always @(negedge clk) begin
    logic        e_ig, e_dg, e_mis, e_rw;
    logic [31:0] e_addr, e_din;
    logic [1:0]  e_sz;
    logic [7:0]  b;
    if (!rst_n) begin
      m_run = 0; m_irv = 0; m_drv = 0; m_derr = 0; m_irdata = 0; m_drdata = 0;
      chk("rst_i_gnt", 32'(i_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_mem_rw", 32'(mem_read_write), 32'd0);
      chk("rst_mem_addr", mem_address, 32'd0);
      chk("rst_mem_size", 32'(mem_access_size), 32'd2);
      chk("rst_mem_din", mem_data_in, 32'd0);
      chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_d_err", 32'(d_err), 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_starve", 32'(starve_cnt), 32'd0);
    end else begin
      e_ig = i_req && (!d_req || m_run == LIM);
      e_dg = d_req && !e_ig;
      e_mis = e_dg && misal(d_size, d_addr);
      e_addr = 32'd0; e_rw = 1'b0; e_sz = 2'd2; e_din = 32'd0;
      if (e_dg) begin
        e_addr = d_addr; e_rw = d_rw && !e_mis; e_sz = d_size; e_din = d_wdata;
      end else if (e_ig) begin
        e_addr = i_addr;
      end
      chk("i_gnt", 32'(i_gnt), 32'(e_ig));
      chk("d_gnt", 32'(d_gnt), 32'(e_dg));
      chk("mem_addr", mem_address, e_addr);
      chk("mem_rw", 32'(mem_read_write), 32'(e_rw));
      chk("mem_size", 32'(mem_access_size), 32'(e_sz));
      chk("mem_din", mem_data_in, e_din);
      chk("starve_cnt", 32'(starve_cnt), 32'(m_run));
      chk("i_rvalid", 32'(i_rvalid), 32'(m_irv));
      chk("i_rdata", i_rdata, m_irdata);
      chk("d_rvalid", 32'(d_rvalid), 32'(m_drv));
      chk("d_rdata", d_rdata, m_drdata);
      chk("d_err", 32'(d_err), 32'(m_derr));
      // advance to the state seen after the coming edge
      m_run = (e_dg && i_req) ? ((m_run < LIM) ? m_run + 1 : LIM) : 0;
      m_irv = e_ig;
      if (e_ig) m_irdata = ref_rd(i_addr);
      m_drv = e_dg;
      m_derr = e_mis;
      if (e_dg) m_drdata = (d_rw || e_mis) ? 32'd0 : ref_rd(d_addr);
      if (e_dg && d_rw && !e_mis) begin
        b = d_addr[7:0];
        ref_mem[b] = d_wdata[7:0];
        if (d_size != 2'd0) ref_mem[b + 8'd1] = d_wdata[15:8];
        if (d_size[1]) begin
          ref_mem[b + 8'd2] = d_wdata[23:16];
          ref_mem[b + 8'd3] = d_wdata[31:24];
        end
      end
    end
  end

  // ---------------- driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_drive(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    d_req = 1'b1; d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  // ---------------- directed scenarios
  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 8'(k) ^ 8'h5A;
    ram[0] = 8'h33; ram[1] = 8'h03; ram[2] = 8'h94; ram[3] = 8'h00;
    ram[4] = 8'hB3; ram[5] = 8'h03; ram[6] = 8'h39; ram[7] = 8'h41;
    for (int k = 0; k < 256; k++) ref_mem[k] = ram[k];

    repeat (3) step();

    // first fetch right after reset release
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    #1 chk("lit_i_gnt_first", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    chk("lit_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("lit_i_rdata0", i_rdata, 32'h00940333);

    // word store then load of the same address
    d_drive(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    step();
    chk("lit_st_rvalid", 32'(d_rvalid), 32'd1);
    chk("lit_st_rdata", d_rdata, 32'd0);
    d_drive(1'b0, 2'd2, 32'h10, 32'd0);
    step();
    d_req = 1'b0;
    chk("lit_ld_rvalid", 32'(d_rvalid), 32'd1);
    chk("lit_ld_rdata", d_rdata, 32'hDEADBEEF);
    step();
    chk("lit_d_rvalid_idle", 32'(d_rvalid), 32'd0);

    // continuous contention: D,D,D,D,I repeating
    i_req = 1'b1; i_addr = 32'h0;
    d_drive(1'b0, 2'd2, 32'h10, 32'd0);
    for (int k = 0; k < 10; k++) begin
      #1 chk("lit_pattern", {30'd0, i_gnt, d_gnt}, (k % 5 == 4) ? 32'd2 : 32'd1);
      step();
      if (k % 5 == 4) chk("lit_starve_clr", 32'(starve_cnt), 32'd0);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // misaligned word store is rejected and leaves memory alone
    d_drive(1'b1, 2'd2, 32'h6, 32'h11223344);
    #1 chk("lit_mis_rw", 32'(mem_read_write), 32'd0);
    step();
    chk("lit_mis_err", 32'(d_err), 32'd1);
    chk("lit_mis_rvalid", 32'(d_rvalid), 32'd1);
    chk("lit_mis_rdata", d_rdata, 32'd0);
    d_drive(1'b0, 2'd2, 32'h4, 32'd0);
    step();
    d_req = 1'b0;
    chk("lit_mis_keep", d_rdata, 32'h413903B3);
    chk("lit_mis_err_clr", 32'(d_err), 32'd0);
`endif

    // byte store then fetch of the containing word
    d_drive(1'b1, 2'd0, 32'h5, 32'h000000AB);
    step();
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h4;
    step();
    i_req = 1'b0;
    chk("lit_byte_fetch", i_rdata, 32'h4139ABB3);

    // half store then word load
    d_drive(1'b1, 2'd1, 32'h12, 32'h0000CAFE);
    step();
    d_drive(1'b0, 2'd2, 32'h10, 32'd0);
    step();
    d_req = 1'b0;
    chk("lit_half", d_rdata, 32'hCAFEBEEF);

    // reset pulsed during a contended D store
    i_req = 1'b1; i_addr = 32'h0;
    d_drive(1'b1, 2'd2, 32'h20, 32'h00000055);
    step();
    step();
    #1 chk("lit_pre_rst_gnt", 32'(d_gnt), 32'd1);
    chk("lit_pre_rst_starve", 32'(starve_cnt), 32'd2);
    rst_n = 1'b0;
    #1 chk("lit_rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("lit_rst_mem_rw", 32'(mem_read_write), 32'd0);
    chk("lit_rst_starve", 32'(starve_cnt), 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("lit_post_rst_drv", 32'(d_rvalid), 32'd0);
    chk("lit_post_rst_irv", 32'(i_rvalid), 32'd0);
    d_drive(1'b0, 2'd2, 32'h10, 32'd0);
    step();
    d_req = 1'b0;
    chk("lit_post_rst_ld", d_rdata, 32'hCAFEBEEF);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
